seg7_hex_encoder: RTL and testbench
===================================

# seg7_hex_encoder

Reverse path of the hex-to-seven-segment decode: samples a seven-segment drive bus {a,b,c,d,e,f,g} plus dot, waits for the pattern to be stable, and maps it back to a 4-bit hex nibble delivered over a valid/ready handshake. It is used for self-checking display paths, monitoring an external display driver, and recovering digits from segment-level stimulus. Unknown patterns raise an error pulse. A full symbol arriving while the previous one is still unaccepted sets a sticky overrun flag.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted (legal range 1..255).
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg  input  7  segment bus, seg[6]=a … seg[0]=g, active-high (see Configuration).
- dot  input  1  decimal-point segment.
- hex_ready  input  1  consumer accepts hex when high with hex_valid.
- hex  output  4  decoded nibble.
- hex_dot  output  1  dot value captured with hex.
- hex_valid  output  1  hex/hex_dot hold a symbol not yet accepted.
- err  output  1  one-cycle pulse: stable pattern is not in the code table.
- ovf  output  1  sticky overrun flag.

## Operation
- Input stage: when {seg,dot} differs from the held sample seg_q, load seg_q and clear the counter cnt. Otherwise, increment cnt, saturating at STABLE_CYCLES.
- Stable event: occurs on the edge where {seg,dot}==seg_q and cnt==STABLE_CYCLES-1. It fires once per stable run.
- Event filter: compare the event pattern with last_seg (7 bits, segments only; reset value 7'b0000000). If equal, the event is ignored. If different, update last_seg and classify the pattern:
  - Blank 7'b0000000: no output. This re-arms the same digit.
  - Code table hit: emit. 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Any other pattern: err=1 for one cycle, no emit.
- Dot-only changes restart stability but do not by themselves re-emit, because the filter compares segments only.
- FSM, two states:
  - IDLE: hex_valid=0. An emit loads hex and hex_dot, sets hex_valid, and moves to FULL.
  - FULL: hex_valid=1, and hex/hex_dot are frozen. hex_ready=1 with no emit returns to IDLE. An emit together with hex_ready=1 loads the new symbol and stays in FULL, with no bubble. An emit with hex_ready=0 sets ovf=1, drops the new symbol, and holds the old one. last_seg still updates.
- ovf clears only on rst.

## Timing
- Reset values: hex=0, hex_dot=0, hex_valid=0, err=0, ovf=0, seg_q=0, cnt=0, last_seg=0, state IDLE.
- Latency: with a pattern first present at edge E0, hex_valid and hex are visible after edge E0+STABLE_CYCLES.
  - STABLE_CYCLES=1 gives 1 cycle after capture.
- Any change before that edge restarts the count from the change edge.
- err asserts after the same edge that would have emitted, for exactly one cycle.
- Handshake: transfer happens on an edge with hex_valid=1 and hex_ready=1. hex_valid falls after that edge unless a simultaneous emit occurs.
- Asynchronous rst mid-operation clears all state immediately. The next symbol needs a full STABLE_CYCLES run after rst deasserts.
- The counter saturates. A pattern held indefinitely emits once.

## Configuration
- SEG7_ACTIVE_LOW_EN defined: seg and dot are inverted at the input before any other logic, for common-anode drivers. Blank is then all-ones on the pins, and hex_dot reports the inverted (logical) value.
- Not defined: pins are used as-is, active-high.

## Test plan
- Basic decode:
  - Stimulus: STABLE_CYCLES=4, hex_ready=1; seg=1111110 from E0, then 0110000 from E10.
  - Required: hex=0 valid after E4, hex=1 valid after E14; each hex_valid lasts one cycle.
- Glitch rejection:
  - Stimulus: seg=1101101 for 3 cycles, 1111001 for 2 cycles, then 1101101 held.
  - Required: exactly one symbol, hex=2; nothing emitted for the glitch.
- Repeat and blank:
  - Stimulus: seg=1011011 held 20 cycles, 0000000 held 5, then 1011011 again.
  - Required: two emits of hex=5, no err.
- Invalid pattern:
  - Stimulus: seg=1010101 held.
  - Required: err pulses one cycle after E0+4, hex_valid stays 0.
- Backpressure and overrun:
  - Stimulus: hex_ready=0; emit A (1110111), then stable E (1001111).
  - Required: hex=A held, ovf=1.
  - Then: hex_ready=1 with a simultaneous emit of F (1000111) gives hex=F with hex_valid continuously high.
- Reset and macro:
  - Stimulus: assert rst mid-count.
  - Required: all outputs 0 immediately.
  - With SEG7_ACTIVE_LOW_EN: pins 0000001 held, dot pin 0, decode to hex=0 with hex_dot=1.

Source files
------------

// File: rtl/seg7_hex_encoder.sv
// Seven-segment to hex encoder: debounces {seg,dot}, maps each new stable pattern to a nibble on valid/ready.
// Optional macro SEG7_ACTIVE_LOW_EN inverts seg/dot at the pins for common-anode drivers.
module seg7_hex_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       dot,
    input  logic       hex_ready,
    output logic [3:0] hex,
    output logic       hex_dot,
    output logic       hex_valid,
    output logic       err,
    output logic       ovf
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);

    // Handshake: a symbol moves on any rising edge where hex_valid and hex_ready are both high;
    // hex/hex_dot stay frozen while hex_valid is high and unaccepted.
    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    // {hit, nibble}; blank and unknown patterns both miss
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = {1'b1, 4'h0};
            7'b0110000: decode = {1'b1, 4'h1};
            7'b1101101: decode = {1'b1, 4'h2};
            7'b1111001: decode = {1'b1, 4'h3};
            7'b0110011: decode = {1'b1, 4'h4};
            7'b1011011: decode = {1'b1, 4'h5};
            7'b1011111: decode = {1'b1, 4'h6};
            7'b1110000: decode = {1'b1, 4'h7};
            7'b1111111: decode = {1'b1, 4'h8};
            7'b1111011: decode = {1'b1, 4'h9};
            7'b1110111: decode = {1'b1, 4'hA};
            7'b0011111: decode = {1'b1, 4'hB};
            7'b1001110: decode = {1'b1, 4'hC};
            7'b0111101: decode = {1'b1, 4'hD};
            7'b1001111: decode = {1'b1, 4'hE};
            7'b1000111: decode = {1'b1, 4'hF};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    logic [7:0] sample;
`ifdef SEG7_ACTIVE_LOW_EN
    assign sample = ~{seg, dot};
`else
    assign sample = {seg, dot};
`endif

    logic [7:0] seg_q, seg_d;
    logic [7:0] cnt_q, cnt_d;
    logic       same;
    logic       stable_evt;

    assign same       = (sample == seg_q);
    assign stable_evt = same && (cnt_q == CNT_LAST);

    // Counter saturates at STABLE_CYCLES so CNT_LAST is crossed once per stable run
    always_comb begin
        seg_d = seg_q;
        cnt_d = cnt_q;
        if (!same) begin
            seg_d = sample;
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    logic [6:0] last_q, last_d;
    logic [4:0] dec;
    logic       emit;
    logic       err_d;

    // Only segment changes reach the classifier; a dot-only change is filtered out here
    always_comb begin
        dec    = decode(seg_q[7:1]);
        last_d = last_q;
        emit   = 1'b0;
        err_d  = 1'b0;
        if (stable_evt && (seg_q[7:1] != last_q)) begin
            last_d = seg_q[7:1];
            if (dec[4]) begin
                emit = 1'b1;
            end else if (seg_q[7:1] != 7'b0000000) begin
                err_d = 1'b1;
            end
        end
    end

    state_e     state_q, state_d;
    logic [3:0] hex_q, hex_d;
    logic       hex_dot_q, hex_dot_d;
    logic       ovf_q, ovf_d;
    logic       err_q;

    always_comb begin
        state_d   = state_q;
        hex_d     = hex_q;
        hex_dot_d = hex_dot_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (emit) begin
                    hex_d     = dec[3:0];
                    hex_dot_d = seg_q[0];
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (emit) begin
                    if (hex_ready) begin
                        hex_d     = dec[3:0];
                        hex_dot_d = seg_q[0];
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (hex_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q     <= 8'd0;
            cnt_q     <= 8'd0;
            last_q    <= 7'd0;
            state_q   <= IDLE;
            hex_q     <= 4'd0;
            hex_dot_q <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            state_q   <= state_d;
            hex_q     <= hex_d;
            hex_dot_q <= hex_dot_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign hex       = hex_q;
    assign hex_dot   = hex_dot_q;
    assign hex_valid = (state_q == FULL);
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg7_hex_encoder.sv
// Bench for seg7_hex_encoder: expected {hex_dot,hex} queued at stimulus time, popped on each transfer.
`timescale 1ns/1ps
module tb_seg7_hex_encoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg;
    logic       dot;
    logic       hex_ready;
    logic [3:0] hex;
    logic       hex_dot;
    logic       hex_valid;
    logic       err;
    logic       ovf;

    int         n_vec = 0;
    int         n_miss = 0;
    int         err_seen = 0;
    int         xfer_seen = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_item;

    always #5 clk = ~clk;

    seg7_hex_encoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg       (seg),
        .dot       (dot),
        .hex_ready (hex_ready),
        .hex       (hex),
        .hex_dot   (hex_dot),
        .hex_valid (hex_valid),
        .err       (err),
        .ovf       (ovf)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Logical segment values; pin polarity applied here
    task automatic drive(input logic [6:0] s, input logic d);
`ifdef SEG7_ACTIVE_LOW_EN
        seg = ~s;
        dot = ~d;
`else
        seg = s;
        dot = d;
`endif
    endtask

    task automatic settle();
        drive(7'b0000000, 1'b0);
        tick(STABLE + 4);
    endtask

    // Scoreboard: one pop per accepted symbol
    always @(negedge clk) begin
        if (!rst && hex_valid === 1'b1 && hex_ready === 1'b1) begin
            n_vec++;
            xfer_seen++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_symbol: got dot=%b hex=%h, none expected", hex_dot, hex);
            end else begin
                exp_item = exp_q.pop_front();
                if ({hex_dot, hex} !== exp_item) begin
                    n_miss++;
                    $display("FAIL symbol: got dot=%b hex=%h, want dot=%b hex=%h",
                             hex_dot, hex, exp_item[4], exp_item[3:0]);
                end
            end
        end
        if (err === 1'b1) err_seen++;
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({hex, hex_dot, hex_valid, err, ovf} !== 8'b0) begin
            n_miss++;
            $display("FAIL reset_outputs: got hex=%h dot=%b valid=%b err=%b ovf=%b, want all 0",
                     hex, hex_dot, hex_valid, err, ovf);
        end
        tick(2);
        rst = 1'b0;
        tick(STABLE + 2);
        n_vec++;
        if ({hex_valid, err, ovf} !== 3'b0) begin
            n_miss++;
            $display("FAIL reset_idle: got valid=%b err=%b ovf=%b, want 0 0 0", hex_valid, err, ovf);
        end
    endtask

    task automatic test_basic_decode();
        hex_ready = 1'b1;
        drive(7'b1111110, 1'b0);
        exp_q.push_back({1'b0, 4'h0});
        tick(STABLE);
        n_vec++;
        if (hex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_early: got valid=%b, want 0", hex_valid);
        end
        tick(1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'h0) begin
            n_miss++;
            $display("FAIL basic_hex0: got valid=%b hex=%h, want valid=1 hex=0", hex_valid, hex);
        end
        tick(1);
        n_vec++;
        if (hex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_one_cycle: got valid=%b, want 0", hex_valid);
        end
        tick(4);
        drive(7'b0110000, 1'b0);
        exp_q.push_back({1'b0, 4'h1});
        tick(STABLE + 1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'h1) begin
            n_miss++;
            $display("FAIL basic_hex1: got valid=%b hex=%h, want valid=1 hex=1", hex_valid, hex);
        end
        tick(1);
        n_vec++;
        if (hex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_one_cycle2: got valid=%b, want 0", hex_valid);
        end
        settle();
    endtask

    task automatic test_glitch();
        int x0;
        x0 = xfer_seen;
        drive(7'b1101101, 1'b0);
        tick(3);
        drive(7'b1111001, 1'b0);
        tick(2);
        drive(7'b1101101, 1'b0);
        exp_q.push_back({1'b0, 4'h2});
        tick(STABLE);
        n_vec++;
        if (hex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL glitch_early: got valid=%b, want 0", hex_valid);
        end
        tick(1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'h2) begin
            n_miss++;
            $display("FAIL glitch_hex2: got valid=%b hex=%h, want valid=1 hex=2", hex_valid, hex);
        end
        tick(STABLE);
        settle();
        n_vec++;
        if (xfer_seen - x0 !== 1) begin
            n_miss++;
            $display("FAIL glitch_count: got %0d symbols, want 1", xfer_seen - x0);
        end
    endtask

    task automatic test_repeat_blank();
        int x0;
        int e0;
        x0 = xfer_seen;
        e0 = err_seen;
        drive(7'b1011011, 1'b0);
        exp_q.push_back({1'b0, 4'h5});
        tick(20);
        drive(7'b0000000, 1'b0);
        tick(5);
        drive(7'b1011011, 1'b0);
        exp_q.push_back({1'b0, 4'h5});
        tick(STABLE + 4);
        settle();
        n_vec++;
        if (xfer_seen - x0 !== 2 || err_seen - e0 !== 0) begin
            n_miss++;
            $display("FAIL repeat_blank: got %0d symbols %0d errs, want 2 symbols 0 errs",
                     xfer_seen - x0, err_seen - e0);
        end
    endtask

    task automatic test_dot_only();
        int x0;
        x0 = xfer_seen;
        drive(7'b1111001, 1'b0);
        exp_q.push_back({1'b0, 4'h3});
        tick(STABLE + 3);
        drive(7'b1111001, 1'b1);
        tick(STABLE + 3);
        n_vec++;
        if (hex_valid !== 1'b0 || xfer_seen - x0 !== 1) begin
            n_miss++;
            $display("FAIL dot_only: got valid=%b symbols=%0d, want valid=0 symbols=1",
                     hex_valid, xfer_seen - x0);
        end
        settle();
    endtask

    task automatic test_invalid();
        int e0;
        e0 = err_seen;
        drive(7'b1010101, 1'b0);
        tick(STABLE);
        n_vec++;
        if (err !== 1'b0) begin
            n_miss++;
            $display("FAIL invalid_early: got err=%b, want 0", err);
        end
        tick(1);
        n_vec++;
        if (err !== 1'b1 || hex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL invalid_err: got err=%b valid=%b, want err=1 valid=0", err, hex_valid);
        end
        tick(1);
        n_vec++;
        if (err !== 1'b0) begin
            n_miss++;
            $display("FAIL invalid_pulse: got err=%b, want 0", err);
        end
        tick(6);
        n_vec++;
        if (hex_valid !== 1'b0 || err_seen - e0 !== 1) begin
            n_miss++;
            $display("FAIL invalid_hold: got valid=%b errs=%0d, want valid=0 errs=1",
                     hex_valid, err_seen - e0);
        end
        settle();
    endtask

    task automatic test_backpressure();
        hex_ready = 1'b0;
        drive(7'b1110111, 1'b0);
        exp_q.push_back({1'b0, 4'hA});
        tick(STABLE + 1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'hA || ovf !== 1'b0) begin
            n_miss++;
            $display("FAIL bp_holdA: got valid=%b hex=%h ovf=%b, want 1 A 0", hex_valid, hex, ovf);
        end
        drive(7'b1001111, 1'b0);
        tick(STABLE + 2);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'hA || ovf !== 1'b1) begin
            n_miss++;
            $display("FAIL bp_overrun: got valid=%b hex=%h ovf=%b, want 1 A 1", hex_valid, hex, ovf);
        end
        drive(7'b1000111, 1'b0);
        exp_q.push_back({1'b0, 4'hF});
        tick(STABLE);
        hex_ready = 1'b1;
        #3;
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'hA) begin
            n_miss++;
            $display("FAIL bp_pre_swap: got valid=%b hex=%h, want 1 A", hex_valid, hex);
        end
        tick(1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'hF) begin
            n_miss++;
            $display("FAIL bp_swap: got valid=%b hex=%h, want 1 F", hex_valid, hex);
        end
        tick(1);
        n_vec++;
        if (hex_valid !== 1'b0 || ovf !== 1'b1) begin
            n_miss++;
            $display("FAIL bp_drain: got valid=%b ovf=%b, want valid=0 ovf=1", hex_valid, ovf);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        hex_ready = 1'b0;
        drive(7'b1111111, 1'b1);
        tick(STABLE + 1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'h8 || hex_dot !== 1'b1 || ovf !== 1'b1) begin
            n_miss++;
            $display("FAIL rst_pre: got valid=%b hex=%h dot=%b ovf=%b, want 1 8 1 1",
                     hex_valid, hex, hex_dot, ovf);
        end
        drive(7'b1111011, 1'b1);
        tick(2);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({hex, hex_dot, hex_valid, err, ovf} !== 8'b0) begin
            n_miss++;
            $display("FAIL rst_async: got hex=%h dot=%b valid=%b err=%b ovf=%b, want all 0",
                     hex, hex_dot, hex_valid, err, ovf);
        end
        tick(1);
        rst = 1'b0;
        hex_ready = 1'b1;
        exp_q.push_back({1'b1, 4'h9});
        tick(STABLE);
        n_vec++;
        if (hex_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_restart_early: got valid=%b, want 0", hex_valid);
        end
        tick(1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'h9 || hex_dot !== 1'b1) begin
            n_miss++;
            $display("FAIL rst_restart: got valid=%b hex=%h dot=%b, want 1 9 1", hex_valid, hex, hex_dot);
        end
        tick(1);
        settle();
    endtask

`ifdef SEG7_ACTIVE_LOW_EN
    task automatic test_active_low();
        hex_ready = 1'b1;
        seg = 7'b0000001;
        dot = 1'b0;
        exp_q.push_back({1'b1, 4'h0});
        tick(STABLE + 1);
        n_vec++;
        if (hex_valid !== 1'b1 || hex !== 4'h0 || hex_dot !== 1'b1) begin
            n_miss++;
            $display("FAIL active_low: got valid=%b hex=%h dot=%b, want 1 0 1", hex_valid, hex, hex_dot);
        end
        tick(1);
        settle();
    endtask
`endif

    initial begin
        hex_ready = 1'b1;
        drive(7'b0000000, 1'b0);
        test_reset();
        test_basic_decode();
        test_glitch();
        test_repeat_blank();
        test_dot_only();
        test_invalid();
        test_backpressure();
        test_reset_mid();
`ifdef SEG7_ACTIVE_LOW_EN
        test_active_low();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL leftover: got %0d symbols never delivered, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
